lsu_axil_master: RTL and testbench
==================================

LSU_AXIL_MASTER -- requirements
Module: lsu_axil_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255, meaning the cycles a transaction may wait in any bus state before an error response (0 = timeout disabled).
REQ-002 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have core-side ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in 32 (`MemAddrBus), req_wdata in 32 (`MemBus), req_wstrb in 4.
REQ-005 SHALL have core-side ports rsp_valid out 1 (one-cycle pulse), rsp_rdata out 32, rsp_err out 1.
REQ-006 SHALL have AXI4-Lite master ports m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1.
REQ-007 SHALL have AXI4-Lite master ports m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1, m_axi_rdata in 32, m_axi_rvalid in 1, m_axi_rready out 1; there is no B channel, and a write completes on its AW/W handshakes.

Function
REQ-008 SHALL implement FSM states IDLE, WR, AR, RD, one transaction outstanding at a time.
REQ-009 SHALL drive req_ready=1 only in IDLE; on req_valid&req_ready it latches addr/wdata/wstrb and goes to WR if req_we=1, else to AR.
REQ-010 SHALL drive all AXI outputs from registers, with valid asserted starting the cycle after acceptance.
REQ-011 In WR, SHALL assert awvalid until the AW handshake and wvalid until the W handshake, each tracked by its own done flag; the handshakes may occur in the same or different cycles, in either order.
REQ-012 SHALL leave WR once both AW and W are done, and SHALL pulse rsp_valid=1 with rsp_err=0 and rsp_rdata=0 in the next cycle.
REQ-013 In AR, SHALL assert arvalid until arready and then go to RD; rready SHALL be 0 outside RD.
REQ-014 In RD, SHALL hold rready=1; on rvalid it captures rdata and pulses rsp_valid with rsp_rdata=captured value and rsp_err=0 in the next cycle.
REQ-015 SHALL return to IDLE in the same cycle rsp_valid is high, so req_ready=1 in the rsp_valid cycle.
REQ-016 Minimum latency with a zero-wait slave SHALL be: write, accept at cycle 0 -> rsp_valid at cycle 2; read (data one cycle after AR) -> rsp_valid at cycle 3.
REQ-017 SHALL hold addr/data/strb stable on the bus while valid is high; core inputs are ignored outside the acceptance cycle.
REQ-018 SHALL apply the timeout as follows: if TIMEOUT_CYC>0 and a counter, cleared on acceptance and incremented in WR/AR/RD, reaches TIMEOUT_CYC, it deasserts all valids and rready, pulses rsp_valid with rsp_err=1 and rsp_rdata=0, and returns to IDLE.
REQ-019 If completion and timeout occur in the same cycle, completion SHALL win (rsp_err=0).
REQ-020 Late slave responses after a timeout SHALL NOT be consumed, because rready stays 0; recovery is system-level.
REQ-021 SHALL forward address bits [1:0] unchanged, with no alignment check.

Reset
REQ-022 While rst_n=0 at a clock edge, SHALL set state IDLE, all valids and rready to 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, done flags and timeout counter 0, and address/data/strobe registers 0.
REQ-023 Reset asserted mid-transaction SHALL abandon the transaction, with no rsp_valid, and outputs SHALL take reset values at that edge.
REQ-024 req_ready SHALL be 1 on the first cycle after reset release.

Structure
REQ-025 FSM state encodings and the default TIMEOUT_CYC SHALL live in the shared defines.v, and bus widths SHALL use the existing `MemAddrBus/`MemBus.
REQ-026 The block SHALL be a single module with no sub-modules, the timeout counter being inline; it connects directly to the AXI4-Lite slave port of the SRAM.

Verification
REQ-027 The bench SHALL cover: write req addr=0x10, wdata=0xDEADBEEF, wstrb=0xF to a zero-wait slave -> awvalid/wvalid high in cycle 1, rsp_valid at cycle 2, rsp_err=0.
REQ-028 The bench SHALL cover: read of 0x10 after the above -> arvalid cycle 1, rready in RD, rsp_valid cycle 3, rsp_rdata=0xDEADBEEF.
REQ-029 The bench SHALL cover: slave gives wready 2 cycles before awready -> wvalid drops after the W handshake, awvalid holds, and exactly one rsp_valid follows the AW handshake.
REQ-030 The bench SHALL cover: TIMEOUT_CYC=4 and a slave that never asserts arready -> arvalid high for 4 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0, req_ready=1.
REQ-031 The bench SHALL cover: rst_n=0 while in RD -> next edge all valids/rready=0, no rsp_valid, req_ready=1 after release.
REQ-032 The bench SHALL cover: back-to-back requests with req_valid held -> the second is accepted in the rsp_valid cycle of the first, with no overlap of AXI valids.

Source files
------------

// File: rtl/lsu_axil_master_pkg.sv
// Shared definitions for the LSU AXI4-Lite master:
// memory bus width macros, FSM state encoding and default timeout.
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif

package lsu_axil_master_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        AR   = 2'd2,
        RD   = 2'd3
    } lsu_state_e;

    localparam int unsigned LSU_TIMEOUT_DEF = 255;

endpackage

// File: rtl/lsu_axil_master.sv
// LSU to AXI4-Lite master bridge, one transaction outstanding.
// Ports: core req (valid/ready/we/addr/wdata/wstrb), core rsp
// (valid pulse/rdata/err), AXI4-Lite AW/W/AR/R master channels
// (no B channel: a write completes on its AW and W handshakes).
`ifndef MemAddrBus
`define MemAddrBus 31:0
`endif
`ifndef MemBus
`define MemBus 31:0
`endif

module lsu_axil_master
    import lsu_axil_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = LSU_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [`MemAddrBus] req_addr,
    input  logic [`MemBus]     req_wdata,
    input  logic [3:0]         req_wstrb,
    output logic               rsp_valid,
    output logic [`MemBus]     rsp_rdata,
    output logic               rsp_err,
    output logic [`MemAddrBus] m_axi_awaddr,
    output logic               m_axi_awvalid,
    input  logic               m_axi_awready,
    output logic [`MemBus]     m_axi_wdata,
    output logic [3:0]         m_axi_wstrb,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    output logic [`MemAddrBus] m_axi_araddr,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [`MemBus]     m_axi_rdata,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready
);

    lsu_state_e         state_q, state_d;
    logic [`MemAddrBus] addr_q, addr_d;
    logic [`MemBus]     wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               aw_done_q, aw_done_d;
    logic               w_done_q, w_done_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               awvalid_q, awvalid_d;
    logic               wvalid_q, wvalid_d;
    logic               arvalid_q, arvalid_d;
    logic               rready_q, rready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [`MemBus]     rsp_rdata_q, rsp_rdata_d;
    logic               rsp_err_q, rsp_err_d;

    logic aw_hs, w_hs, ar_hs, r_hs;
    logic aw_fin, w_fin, timeout_hit;

    assign aw_hs  = awvalid_q & m_axi_awready;
    assign w_hs   = wvalid_q & m_axi_wready;
    assign ar_hs  = arvalid_q & m_axi_arready;
    assign r_hs   = rready_q & m_axi_rvalid;
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    // ">=" so a counter that overshoots (e.g. AR handshake on the
    // expiry cycle) still expires in RD instead of never matching.
    assign timeout_hit = (TIMEOUT_CYC != 0) &&
                         ((cnt_q + 32'd1) >= TIMEOUT_CYC);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        cnt_d       = cnt_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_we) begin
                        state_d   = WR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            WR: begin
                cnt_d = cnt_q + 32'd1;
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_fin && w_fin) begin
                    state_d     = IDLE;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    awvalid_d   = 1'b0;
                    wvalid_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            AR: begin
                cnt_d = cnt_q + 32'd1;
                if (ar_hs) begin
                    state_d   = RD;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    arvalid_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            RD: begin
                cnt_d = cnt_q + 32'd1;
                if (r_hs) begin
                    state_d     = IDLE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = m_axi_rdata;
                end else if (timeout_hit) begin
                    state_d     = IDLE;
                    rready_d    = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            cnt_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            cnt_q       <= cnt_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_err       = rsp_err_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule

// File: tb/tb_lsu_axil_master.sv
// Directed bench for lsu_axil_master with a hand-driven slave.
// Inputs are driven and outputs sampled 1 time unit after posedge.
module tb_lsu_axil_master;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [31:0] m_axi_araddr;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    int checks = 0;
    int errors = 0;
    logic [31:0] mem;

    lsu_axil_master #(.TIMEOUT_CYC(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_wstrb     (req_wstrb),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_arready = 1'b0;
        m_axi_rdata   = '0;
        m_axi_rvalid  = 1'b0;
        mem           = '0;
        step();
        step();
        chk("rst_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("rst_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("rst_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("rst_rready", 32'(m_axi_rready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_awaddr", m_axi_awaddr, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rel_req_ready", 32'(req_ready), 32'd1);

        // Write 0x10 <- DEADBEEF, zero-wait slave
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h10;
        req_wdata = 32'hDEADBEEF;
        req_wstrb = 4'hF;
        chk("w0_req_ready", 32'(req_ready), 32'd1);
        step();
        req_valid = 1'b0;
        req_wdata = 32'h0;
        chk("w1_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("w1_wvalid", 32'(m_axi_wvalid), 32'd1);
        chk("w1_awaddr", m_axi_awaddr, 32'h10);
        chk("w1_wdata", m_axi_wdata, 32'hDEADBEEF);
        chk("w1_wstrb", 32'(m_axi_wstrb), 32'hF);
        chk("w1_req_ready", 32'(req_ready), 32'd0);
        chk("w1_rsp_valid", 32'(rsp_valid), 32'd0);
        if (m_axi_wvalid && m_axi_wready) mem = m_axi_wdata;
        step();
        chk("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("w2_rsp_err", 32'(rsp_err), 32'd0);
        chk("w2_rsp_rdata", rsp_rdata, 32'd0);
        chk("w2_req_ready", 32'(req_ready), 32'd1);
        chk("w2_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("w2_wvalid", 32'(m_axi_wvalid), 32'd0);
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        step();
        chk("w3_rsp_valid", 32'(rsp_valid), 32'd0);

        // Read 0x10, data one cycle after AR
        m_axi_arready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h10;
        step();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        chk("r1_arvalid", 32'(m_axi_arvalid), 32'd1);
        chk("r1_araddr", m_axi_araddr, 32'h10);
        chk("r1_rready", 32'(m_axi_rready), 32'd0);
        step();
        m_axi_arready = 1'b0;
        chk("r2_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("r2_rready", 32'(m_axi_rready), 32'd1);
        chk("r2_rsp_valid", 32'(rsp_valid), 32'd0);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = mem;
        step();
        m_axi_rvalid = 1'b0;
        m_axi_rdata  = '0;
        chk("r3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("r3_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
        chk("r3_rsp_err", 32'(rsp_err), 32'd0);
        chk("r3_rready", 32'(m_axi_rready), 32'd0);
        chk("r3_req_ready", 32'(req_ready), 32'd1);
        step();

        // W accepted two cycles before AW, unaligned address
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h27;
        req_wdata = 32'h12345678;
        req_wstrb = 4'h3;
        step();
        req_valid = 1'b0;
        m_axi_wready = 1'b1;
        chk("s1_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("s1_wvalid", 32'(m_axi_wvalid), 32'd1);
        chk("s1_awaddr", m_axi_awaddr, 32'h27);
        step();
        m_axi_wready = 1'b0;
        chk("s2_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("s2_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("s2_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("s3_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("s3_awaddr", m_axi_awaddr, 32'h27);
        chk("s3_rsp_valid", 32'(rsp_valid), 32'd0);
        m_axi_awready = 1'b1;
        step();
        m_axi_awready = 1'b0;
        chk("s4_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("s4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s4_rsp_err", 32'(rsp_err), 32'd0);
        step();
        chk("s5_rsp_valid", 32'(rsp_valid), 32'd0);

        // Read timeout: arready never rises, TIMEOUT_CYC=4
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 32'h40;
        step();
        req_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("t%0d_arvalid", i), 32'(m_axi_arvalid), 32'd1);
            chk($sformatf("t%0d_rsp_valid", i), 32'(rsp_valid), 32'd0);
            step();
        end
        chk("t5_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("t5_rsp_err", 32'(rsp_err), 32'd1);
        chk("t5_rsp_rdata", rsp_rdata, 32'd0);
        chk("t5_req_ready", 32'(req_ready), 32'd1);
        chk("t5_rready", 32'(m_axi_rready), 32'd0);
        step();

        // Reset while in RD
        m_axi_arready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 32'h80;
        step();
        req_valid = 1'b0;
        step();
        m_axi_arready = 1'b0;
        chk("x2_rready", 32'(m_axi_rready), 32'd1);
        rst_n = 1'b0;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'h55AA55AA;
        step();
        m_axi_rvalid = 1'b0;
        chk("x3_rready", 32'(m_axi_rready), 32'd0);
        chk("x3_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("x3_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("x3_rsp_valid", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        step();
        chk("x4_req_ready", 32'(req_ready), 32'd1);
        chk("x4_rsp_valid", 32'(rsp_valid), 32'd0);

        // Back-to-back: write then read, req_valid held
        m_axi_awready = 1'b1;
        m_axi_wready  = 1'b1;
        m_axi_arready = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h100;
        req_wdata = 32'hA5A5A5A5;
        req_wstrb = 4'hF;
        step();
        req_we   = 1'b0;
        req_addr = 32'h10;
        chk("b1_awvalid", 32'(m_axi_awvalid), 32'd1);
        chk("b1_arvalid", 32'(m_axi_arvalid), 32'd0);
        chk("b1_req_ready", 32'(req_ready), 32'd0);
        step();
        chk("b2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b2_req_ready", 32'(req_ready), 32'd1);
        chk("b2_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("b2_arvalid", 32'(m_axi_arvalid), 32'd0);
        step();
        req_valid = 1'b0;
        chk("b3_arvalid", 32'(m_axi_arvalid), 32'd1);
        chk("b3_araddr", m_axi_araddr, 32'h10);
        chk("b3_awvalid", 32'(m_axi_awvalid), 32'd0);
        chk("b3_wvalid", 32'(m_axi_wvalid), 32'd0);
        chk("b3_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 32'hCAFEF00D;
        chk("b4_rready", 32'(m_axi_rready), 32'd1);
        step();
        m_axi_rvalid = 1'b0;
        chk("b5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("b5_rsp_rdata", rsp_rdata, 32'hCAFEF00D);
        chk("b5_rsp_err", 32'(rsp_err), 32'd0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
